// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: 2-flop sync, baud tick divider, oversample counter, frame FSM.
// Define UART_RX_PARITY_EN to compile in the parity bit state and checker.
module uart_rx_core #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DIV_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset_b,
   input  logic                  rx,
   input  logic [DIV_WIDTH-1:0]  baud_div,
   input  logic                  parity_odd,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  parity_err,
   output logic                  frame_err,
   output logic                  busy
);

   localparam int unsigned OSW = $clog2(OVERSAMPLE);
   localparam int unsigned BCW = $clog2(DATA_WIDTH);
   localparam logic [OSW-1:0] OS_MID  = OSW'(OVERSAMPLE / 2 - 1);
   localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
   localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

   state_e                state_q, state_d;
   logic                  rx_meta_q, rx_s_q, rx_prev_q;
   logic [DIV_WIDTH-1:0]  div_q, div_d, div_reload;
   logic [OSW-1:0]        os_q, os_d;
   logic [BCW-1:0]        bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  perr_q, perr_d;
   logic                  dv_q, dv_d, pe_q, pe_d, fe_q, fe_d;
   logic                  tick, start_edge, sample;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         rx_prev_q <= rx_s_q;
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         os_q    <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         perr_q  <= 1'b0;
         dv_q    <= 1'b0;
         pe_q    <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         os_q    <= os_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         perr_q  <= perr_d;
         dv_q    <= dv_d;
         pe_q    <= pe_d;
         fe_q    <= fe_d;
      end
   end

   // baud_div of 0 and 1 both reload to 0, giving a tick every clock
   assign div_reload = (baud_div > DIV_WIDTH'(1)) ? baud_div - DIV_WIDTH'(1) : '0;
   assign tick       = (div_q == '0);
   assign start_edge = (state_q == S_IDLE) && rx_prev_q && !rx_s_q;
   assign sample     = tick && (os_q == OS_LAST);

   always_comb begin
      state_d = state_q;
      div_d   = (start_edge || tick) ? div_reload : div_q - DIV_WIDTH'(1);
      os_d    = tick ? os_q + OSW'(1) : os_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      perr_d  = perr_q;
      dv_d    = 1'b0;
      pe_d    = 1'b0;
      fe_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_edge) state_d = S_START;
         end
         S_START: begin
            bit_d  = '0;
            perr_d = 1'b0;
            if (tick && (os_q == OS_MID)) state_d = rx_s_q ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (sample) begin
               shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
               bit_d   = bit_q + BCW'(1);
`ifdef UART_RX_PARITY_EN
               if (bit_q == BIT_LAST) state_d = S_PARITY;
`else
               if (bit_q == BIT_LAST) state_d = S_STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (sample) begin
               perr_d  = rx_s_q != (^shift_q ^ parity_odd);
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (sample) begin
               if (rx_s_q) begin
                  data_d = shift_q;
                  dv_d   = 1'b1;
                  pe_d   = perr_q;
               end else begin
                  fe_d   = 1'b1;
               end
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // realigning the oversample phase on every transition keeps each sample mid-bit
      if (state_d != state_q) os_d = '0;
   end

   assign data_out   = data_q;
   assign data_valid = dv_q;
   assign frame_err  = fe_q;
   assign busy       = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_err = pe_q;
`else
   logic unused_parity;
   assign unused_parity = parity_odd ^ pe_q;
   assign parity_err    = 1'b0;
`endif

endmodule
